// File: rtl/snes_joy_reader.sv
// SNES controller port initiator: strobes the pad, clocks in 16 active-low bits, presents an active-high button word.
// Define SNES_JOY_READER_AUTOPOLL_EN to add a free-running poll timer that launches reads every POLL_CYC cycles.
module snes_joy_reader #(
  parameter int HALF_CYC = 65,
  parameter int POLL_CYC = 180_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        joy_strb,
  output logic        joy_clk,
  input  logic        joy_di,
  output logic [15:0] joy_word,
  output logic        valid
);

  localparam int              PH_W      = $clog2(2 * HALF_CYC);
  localparam logic [PH_W-1:0] STRB_LAST = PH_W'(2 * HALF_CYC - 1);
  localparam logic [PH_W-1:0] HALF_LAST = PH_W'(HALF_CYC - 1);

  if (HALF_CYC < 4) begin : g_half_cyc_chk
    $error("snes_joy_reader: HALF_CYC must be at least 4");
  end
  if (POLL_CYC < 2) begin : g_poll_cyc_chk
    $error("snes_joy_reader: POLL_CYC must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PH_W-1:0] ph_cnt;
  logic [3:0]      bit_cnt;
  logic [15:0]     shreg;
  logic            ph_end;
  logic            launch;
  logic            strb_d;
  logic            jclk_d;
  logic            busy_d;
  logic            valid_d;
  logic            di_p0;
  logic            di_p1;

  // stage p0/p1: two-flop synchronizer for the asynchronous pad data line
  always_ff @(posedge clk) begin
    di_p0 <= joy_di;
    di_p1 <= di_p0;
  end

`ifdef SNES_JOY_READER_AUTOPOLL_EN
  localparam int            PW        = $clog2(POLL_CYC);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYC - 1);

  logic [PW-1:0] poll_cnt;
  logic          poll_exp;
  logic          poll_pend;

  assign poll_exp = (poll_cnt == POLL_LAST);

  // An expiry that lands mid-read is remembered and served once the FSM is idle again.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      poll_cnt  <= '0;
      poll_pend <= 1'b0;
    end else begin
      poll_cnt <= poll_exp ? '0 : poll_cnt + 1'b1;
      if (state == S_IDLE && state_nxt == S_STROBE) begin
        poll_pend <= 1'b0;
      end else if (poll_exp && state != S_IDLE) begin
        poll_pend <= 1'b1;
      end
    end
  end

  assign launch = start | poll_exp | poll_pend;
`else
  assign launch = start;
`endif

  always_comb begin
    ph_end = 1'b0;
    case (state)
      S_STROBE:      ph_end = (ph_cnt == STRB_LAST);
      S_LOW, S_HIGH: ph_end = (ph_cnt == HALF_LAST);
      default:       ph_end = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (launch) state_nxt = S_STROBE;
      S_STROBE: if (ph_end) state_nxt = S_LOW;
      S_LOW:    if (ph_end) state_nxt = S_HIGH;
      S_HIGH:   if (ph_end) state_nxt = (bit_cnt == 4'd15) ? S_DONE : S_LOW;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state they belong to.
  always_comb begin
    strb_d  = (state_nxt == S_STROBE);
    jclk_d  = (state_nxt == S_HIGH);
    busy_d  = (state_nxt != S_IDLE);
    valid_d = (state_nxt == S_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      joy_strb <= 1'b0;
      joy_clk  <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      joy_word <= 16'h0000;
    end else begin
      joy_strb <= strb_d;
      joy_clk  <= jclk_d;
      busy     <= busy_d;
      valid    <= valid_d;
      if (valid_d) begin
        joy_word <= shreg;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ph_cnt  <= '0;
      bit_cnt <= 4'd0;
      shreg   <= 16'h0000;
    end else begin
      if (state == S_IDLE || state_nxt != state) begin
        ph_cnt <= '0;
      end else begin
        ph_cnt <= ph_cnt + 1'b1;
      end
      if (state == S_IDLE && state_nxt == S_STROBE) begin
        bit_cnt <= 4'd0;
      end else if (state == S_HIGH && ph_end) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
      // Pad drives low for pressed; invert so the first-received bit ends up at bit 0.
      if (state == S_LOW && ph_end) begin
        shreg <= {~di_p1, shreg[15:1]};
      end
    end
  end

endmodule

// File: tb/tb_snes_joy_reader.sv
// Bench for snes_joy_reader: behavioural pad responder, cycle-exact waveform expectations and random button words.
`timescale 1ns/1ps
module tb_snes_joy_reader;

  localparam int H    = 4;
  localparam int POLL = 5000;
  localparam int RD   = 34 * H + 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        joy_di;
  logic        busy;
  logic        joy_strb;
  logic        joy_clk;
  logic        valid;
  logic [15:0] joy_word;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] pad_bits  = 16'h0000;
  logic [15:0] pad_lat   = 16'h0000;
  int          pad_idx   = 0;
  int          pad_mode  = 0;
  logic        manual_di = 1'b1;

  snes_joy_reader #(
    .HALF_CYC(H),
    .POLL_CYC(POLL)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .busy    (busy),
    .joy_strb(joy_strb),
    .joy_clk (joy_clk),
    .joy_di  (joy_di),
    .joy_word(joy_word),
    .valid   (valid)
  );

  always #5 clk = ~clk;

  // Pad responder: latch on strobe rise, advance one button per clock rise, pressed drives low.
  always @(posedge joy_strb or posedge joy_clk) begin
    if (joy_strb) begin
      pad_lat = pad_bits;
      pad_idx = 0;
    end else begin
      pad_idx = pad_idx + 1;
    end
  end

  assign joy_di = (pad_mode == 1) ? 1'b1 :
                  (pad_mode == 2) ? manual_di :
                  (pad_idx < 16)  ? ~pad_lat[pad_idx[3:0]] : 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_read(input string tag, input logic [15:0] exp_w, input bit chained,
                         input bit hold, input bit noise);
    int n;
    int e_strb, e_clk, e_busy, e_valid, n_valid, clk_pulses, strb_pulses;
    logic pc, ps, x_strb, x_clk, x_busy;
    logic [15:0] w;
    e_strb = 0; e_clk = 0; e_busy = 0; e_valid = 0; n_valid = 0;
    clk_pulses = 0; strb_pulses = 0; w = 16'h0000;
    if (!chained) begin
      n = 0;
      while (busy !== 1'b0 && n < 2 * RD) begin
        @(negedge clk);
        n++;
      end
      if (n >= 2 * RD) chk({tag, "_idle_wait"}, 32'(busy), 32'd0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = hold;
    end
    pc = 1'b0;
    ps = 1'b0;
    for (int k = 1; k <= RD; k++) begin
      @(negedge clk);
      if (noise) start = (k % 37 == 5);
      if (k == RD) start = hold;
      x_strb = (k <= 2 * H);
      x_clk  = (k > 2 * H) && (k <= 34 * H) && (((k - 2 * H - 1) % (2 * H)) >= H);
      x_busy = (k <= 34 * H + 1);
      if (joy_strb !== x_strb) e_strb++;
      if (joy_clk !== x_clk) e_clk++;
      if (busy !== x_busy) e_busy++;
      if (joy_clk === 1'b1 && pc === 1'b0) clk_pulses++;
      if (joy_strb === 1'b1 && ps === 1'b0) strb_pulses++;
      pc = joy_clk;
      ps = joy_strb;
      if (valid === 1'b1) begin
        n_valid++;
        if (k != 34 * H + 1) e_valid++;
        w = joy_word;
      end
    end
    chk({tag, "_strb_wave"}, 32'(e_strb), 32'd0);
    chk({tag, "_clk_wave"}, 32'(e_clk), 32'd0);
    chk({tag, "_busy_wave"}, 32'(e_busy), 32'd0);
    chk({tag, "_valid_pos"}, 32'(e_valid), 32'd0);
    chk({tag, "_valid_cnt"}, 32'(n_valid), 32'd1);
    chk({tag, "_clk_pulses"}, 32'(clk_pulses), 32'd16);
    chk({tag, "_strb_pulses"}, 32'(strb_pulses), 32'd1);
    chk({tag, "_word"}, 32'(w), 32'(exp_w));
  endtask

  task automatic reset_mid_read();
    pad_bits = 16'h5A3C;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (17 * H + 2) @(negedge clk);
    chk("rst_pre_clk", 32'(joy_clk), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_strb", 32'(joy_strb), 32'd0);
    chk("rst_mid_clk", 32'(joy_clk), 32'd0);
    chk("rst_mid_valid", 32'(valid), 32'd0);
    chk("rst_mid_word", 32'(joy_word), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic setup_read();
    int n;
    pad_mode  = 2;
    manual_di = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3 * H - 1) @(posedge clk);
    #1 manual_di = 1'b0;
    repeat (4 * H - 2) @(posedge clk);
    #1 manual_di = 1'b1;
    repeat (2 * H + 2) @(posedge clk);
    #1 manual_di = 1'b0;
    n = 0;
    while (valid !== 1'b1 && n < 40 * H) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40 * H) chk("setup_valid_wait", 32'(valid), 32'd1);
    chk("setup_word", 32'(joy_word), 32'h0000FFF2);
    chk("setup_no_x", 32'($isunknown(joy_word)), 32'd0);
    repeat (2) @(negedge clk);
    pad_mode = 0;
  endtask

`ifdef SNES_JOY_READER_AUTOPOLL_EN
  task automatic autopoll_tests();
    int n, rises;
    logic pb;
    pad_bits = 16'($urandom);
    n = 0;
    while (busy !== 1'b1 && n < POLL + 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= POLL + 100) chk("poll_first_wait", 32'(busy), 32'd1);
    pb = 1'b1;
    n = 0;
    while (n < POLL + 100) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1 && pb === 1'b0) break;
      pb = busy;
    end
    chk("poll_period", 32'(n), 32'(POLL));
    repeat (4900) @(negedge clk);
    pad_bits = 16'($urandom);
    do_read("poll_start", pad_bits, 1'b0, 1'b0, 1'b0);
    pad_bits = 16'($urandom);
    do_read("poll_deferred", pad_bits, 1'b1, 1'b0, 1'b0);
    rises = 0;
    pb = busy;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (busy === 1'b1 && pb === 1'b0) rises++;
      pb = busy;
    end
    chk("poll_single_deferred", 32'(rises), 32'd0);
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strb", 32'(joy_strb), 32'd0);
    chk("rst_clk", 32'(joy_clk), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_word", 32'(joy_word), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    pad_bits = 16'h0009;
    do_read("b_start", 16'h0009, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("word_hold", 32'(joy_word), 32'h00000009);
    pad_bits = 16'h0FFF;
    do_read("all12", 16'h0FFF, 1'b0, 1'b0, 1'b0);
    pad_mode = 1;
    do_read("no_pad", 16'h0000, 1'b0, 1'b0, 1'b0);
    pad_mode = 0;
    for (int i = 0; i < 3; i++) begin
      pad_bits = 16'($urandom);
      do_read("rand", pad_bits, 1'b0, 1'b0, 1'b0);
    end

    pad_bits = 16'($urandom);
    do_read("held0", pad_bits, 1'b0, 1'b1, 1'b0);
    pad_bits = 16'($urandom);
    do_read("held1", pad_bits, 1'b1, 1'b1, 1'b0);
    pad_bits = 16'($urandom);
    do_read("held2", pad_bits, 1'b1, 1'b0, 1'b0);

    pad_bits = 16'hC3A5;
    do_read("noise", 16'hC3A5, 1'b0, 1'b0, 1'b1);

    reset_mid_read();
    pad_bits = 16'($urandom);
    do_read("post_rst", pad_bits, 1'b0, 1'b0, 1'b0);

    setup_read();
    for (int i = 0; i < 2; i++) begin
      pad_bits = 16'($urandom);
      do_read("rand_tail", pad_bits, 1'b0, 1'b0, 1'b0);
    end

`ifdef SNES_JOY_READER_AUTOPOLL_EN
    autopoll_tests();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
